axi_lite_to_intbus: RTL

AXI_LITE_TO_INTBUS -- requirements
Module: axi_lite_to_intbus

---
 rtl/intbus_pkg.sv | 17 +
 rtl/intbus_interf.sv | 25 ++
 rtl/intbus_rd_timer.sv | 37 +++
 rtl/axi_lite_to_intbus.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/intbus_pkg.sv
// intbus_pkg: shared types and constants for the AXI4-Lite to intbus bridge.
package intbus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      BRESP,
      RD,
      RWAIT,
      RRESP
   } state_t;

   localparam logic [1:0]  OKAY     = 2'b00;
   localparam logic [1:0]  SLVERR   = 2'b10;
   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/intbus_interf.sv
// intbus_interf: single-master internal bus toward the connectbus hub.
interface intbus_interf #(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 32
);

   logic                  clk;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wr;
   logic                  rd;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  rvalid;

   modport master (
      output clk, addr, wdata, wr, rd,
      input  rdata, rvalid
   );

   modport slave (
      input  clk, addr, wdata, wr, rd,
      output rdata, rvalid
   );

endinterface

// File: rtl/intbus_rd_timer.sv
// intbus_rd_timer: 4-bit read-timeout counter. start arms it at 0, it counts
// every cycle while armed, and hit or expiry disarms it.
module intbus_rd_timer #(
   parameter int unsigned TIMEOUT = 15
)(
   input  logic clk,
   input  logic resetn,
   input  logic start,
   input  logic hit,
   output logic expired
);

   localparam logic [3:0] LIMIT = 4'(TIMEOUT);

   logic [3:0] cnt;
   logic       armed;

   // Counter register: reload on start, advance while armed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt   <= '0;
         armed <= 1'b0;
      end else if (start) begin
         cnt   <= '0;
         armed <= 1'b1;
      end else if (armed) begin
         if (hit || expired) begin
            armed <= 1'b0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   assign expired = armed && (cnt == LIMIT);

endmodule

// File: rtl/axi_lite_to_intbus.sv
// axi_lite_to_intbus: AXI4-Lite slave bridged onto the intbus master port,
// one transaction at a time. Optional build macro AXI_INTBUS_WSTRB_CHECK_EN
// rejects writes with a partial strobe (no bus.wr, SLVERR response).
module axi_lite_to_intbus
   import intbus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 28,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 15,
   parameter logic [31:0] ERR_DATA   = intbus_pkg::ERR_DATA
)(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [31:0]           s_awaddr,
   input  logic                  s_awvalid,
   output logic                  s_awready,
   input  logic [DATA_WIDTH-1:0] s_wdata,
   input  logic [3:0]            s_wstrb,
   input  logic                  s_wvalid,
   output logic                  s_wready,
   output logic [1:0]            s_bresp,
   output logic                  s_bvalid,
   input  logic                  s_bready,
   input  logic [31:0]           s_araddr,
   input  logic                  s_arvalid,
   output logic                  s_arready,
   output logic [DATA_WIDTH-1:0] s_rdata,
   output logic [1:0]            s_rresp,
   output logic                  s_rvalid,
   input  logic                  s_rready,
   intbus_interf.master          bus
);

   state_t                state;
   state_t                state_nxt;
   logic                  aw_take;
   logic                  ar_take;
   logic                  rd_hit;
   logic                  rd_err;
   logic                  wr_pulse;
   logic                  rd_pulse;
   logic                  bvalid;
   logic                  rvalid;
   logic                  wstrb_ok;
   logic                  wr_issue_q;
   logic                  tmr_start;
   logic                  tmr_expired;
   logic                  unused_bits;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [1:0]            bresp_q;
   logic [1:0]            rresp_q;

`ifdef AXI_INTBUS_WSTRB_CHECK_EN
   assign wstrb_ok = (s_wstrb == '1);
`else
   assign wstrb_ok = 1'b1;
`endif

   // Byte-lane bits and address bits above the word window are never used.
   assign unused_bits = ^{s_awaddr, s_araddr, s_wstrb};

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake decode; IDLE accepts are qualified by resetn so
   // the readies stay low while reset is held even if the master drives valid.
   always_comb begin
      state_nxt = state;
      aw_take   = 1'b0;
      ar_take   = 1'b0;
      rd_hit    = 1'b0;
      rd_err    = 1'b0;
      wr_pulse  = 1'b0;
      rd_pulse  = 1'b0;
      bvalid    = 1'b0;
      rvalid    = 1'b0;
      case (state)
         IDLE: begin
            if (resetn && s_awvalid && s_wvalid) begin
               aw_take   = 1'b1;
               state_nxt = WR;
            end else if (resetn && s_arvalid) begin
               ar_take   = 1'b1;
               state_nxt = RD;
            end
         end
         WR: begin
            wr_pulse  = wr_issue_q;
            state_nxt = BRESP;
         end
         BRESP: begin
            bvalid = 1'b1;
            if (s_bready) begin
               state_nxt = IDLE;
            end
         end
         RD: begin
            rd_pulse = 1'b1;
            if (bus.rvalid) begin
               rd_hit    = 1'b1;
               state_nxt = RRESP;
            end else begin
               state_nxt = RWAIT;
            end
         end
         RWAIT: begin
            if (bus.rvalid) begin
               rd_hit    = 1'b1;
               state_nxt = RRESP;
            end else if (tmr_expired) begin
               rd_err    = 1'b1;
               state_nxt = RRESP;
            end
         end
         RRESP: begin
            rvalid = 1'b1;
            if (s_rready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture and read-data/response holding registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         wr_issue_q <= 1'b0;
         bresp_q    <= OKAY;
         rdata_q    <= '0;
         rresp_q    <= OKAY;
      end else begin
         if (aw_take) begin
            addr_q     <= s_awaddr[ADDR_WIDTH+1:2];
            wr_issue_q <= wstrb_ok;
            bresp_q    <= wstrb_ok ? OKAY : SLVERR;
            if (wstrb_ok) begin
               wdata_q <= s_wdata;
            end
         end else if (ar_take) begin
            addr_q <= s_araddr[ADDR_WIDTH+1:2];
         end
         if (rd_hit) begin
            rdata_q <= bus.rdata;
            rresp_q <= OKAY;
         end else if (rd_err) begin
            rdata_q <= ERR_DATA;
            rresp_q <= SLVERR;
         end
      end
   end

   // A zero-latency answer in RD needs no timer run.
   assign tmr_start = rd_pulse & ~bus.rvalid;

   intbus_rd_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_rd_timer (
      .clk     (clk),
      .resetn  (resetn),
      .start   (tmr_start),
      .hit     (rd_hit),
      .expired (tmr_expired)
   );

   assign s_awready = aw_take;
   assign s_wready  = aw_take;
   assign s_arready = ar_take;
   assign s_bvalid  = bvalid;
   assign s_bresp   = bvalid ? bresp_q : OKAY;
   assign s_rvalid  = rvalid;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;

   assign bus.clk   = clk;
   assign bus.addr  = addr_q;
   assign bus.wdata = wdata_q;
   assign bus.wr    = wr_pulse;
   assign bus.rd    = rd_pulse;

endmodule
